mult_single: RTL and testbench

Signed fixed-point multiplier used by the CNN datapath for weight × activation products. It multiplies two two's-complement operands that share the same Q-format, with AUG_FCT_B fractional bits. It rescales the full-precision product back to that format and saturates it to the operand width. It is a two-stage pipeline: it accepts one operation per cycle, has fixed latency, and has no back-pressure.

---
 rtl/mult_single.sv | 92 +++++++++
 tb/tb_mult_single.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mult_single.sv
// Signed fixed-point multiplier for the CNN datapath.
// Two-stage pipeline: stage 1 registers the exact 2*DATA_WID-bit product,
// stage 2 rescales it by AUG_FCT_B fractional bits (floor) and saturates
// it to DATA_WID bits, flagging ovf when clipping occurred.
module mult_single #(
  parameter int DATA_WID  = 16,
  parameter int AUG_FCT_B = 7
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [DATA_WID-1:0] A,
  input  logic [DATA_WID-1:0] B,
  output logic                out_valid,
  output logic [DATA_WID-1:0] OUT,
  output logic                ovf
);

  localparam int PW = 2 * DATA_WID;

  localparam logic [DATA_WID-1:0] SAT_MAX = {1'b0, {(DATA_WID-1){1'b1}}};
  localparam logic [DATA_WID-1:0] SAT_MIN = {1'b1, {(DATA_WID-1){1'b0}}};

  // Operands sign-extended to the full product width so that the multiply
  // is performed at 2*DATA_WID bits and is exact for every operand pair.
  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] b_ext;
  logic signed [PW-1:0] p_next;

  assign a_ext  = {{DATA_WID{A[DATA_WID-1]}}, A};
  assign b_ext  = {{DATA_WID{B[DATA_WID-1]}}, B};
  assign p_next = a_ext * b_ext;

  logic                 v1;
  logic signed [PW-1:0] p_q;

  // Stage 1: capture the full-precision product when an operation arrives.
  // NOTE: sequential state is assigned with <= so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v1  <= 1'b0;
      p_q <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        p_q <= p_next;
      end
    end
  end

  // Rescale with an arithmetic shift (floors toward -inf); the result fits
  // in DATA_WID bits only when all bits from the sign down to bit
  // DATA_WID-1 agree.
  logic signed [PW-1:0]    s_full;
  logic [PW-DATA_WID:0]    s_top;
  logic [DATA_WID-1:0]     sat_out;
  logic                    sat_ovf;

  assign s_full = p_q >>> AUG_FCT_B;
  assign s_top  = s_full[PW-1:DATA_WID-1];

  // Saturation select: clip to the signed range and raise ovf on clipping.
  // NOTE: every output gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    sat_out = s_full[DATA_WID-1:0];
    sat_ovf = 1'b0;
    if (!((&s_top) || !(|s_top))) begin
      sat_ovf = 1'b1;
      sat_out = s_full[PW-1] ? SAT_MIN : SAT_MAX;
    end
  end

  // Stage 2: register the saturated result; hold it across bubbles.
  // NOTE: the product and result registers are reset too, so no stale
  // value from before reset is ever visible on OUT.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      OUT       <= '0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= v1;
      if (v1) begin
        OUT <= sat_out;
        ovf <= sat_ovf;
      end
    end
  end

endmodule

// File: tb/tb_mult_single.sv
// Testbench for mult_single (DATA_WID=16, AUG_FCT_B=7): directed vectors,
// pipeline ordering with a bubble, mid-flight reset, and a random run
// against an arithmetic floor-and-saturate reference model.
module tb_mult_single;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic [15:0] A;
  logic [15:0] B;
  logic        out_valid;
  logic [15:0] OUT;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  // Expected result of the operation issued on the previous step, and the
  // last valid output that OUT/ovf must hold during bubbles.
  logic        pend_v;
  logic [15:0] pend_out;
  logic        pend_ovf;
  logic [15:0] hold_out;
  logic        hold_ovf;

  mult_single #(.DATA_WID(16), .AUG_FCT_B(7)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .A        (A),
    .B        (B),
    .out_valid(out_valid),
    .OUT      (OUT),
    .ovf      (ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: real-valued product / 128 floored, then clipped to int16.
  task automatic ref_mult(input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] o, output logic f);
    longint pa, pb, p, q;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    p  = pa * pb;
    if (p >= 0) q = p / 128;
    else        q = -((-p + 127) / 128);
    if (q > 32767) begin
      o = 16'h7FFF; f = 1'b1;
    end else if (q < -32768) begin
      o = 16'h8000; f = 1'b1;
    end else begin
      o = 16'(q); f = 1'b0;
    end
  endtask

  task automatic check_out(input string tag);
    checks++;
    assert (out_valid === pend_v) else begin
      errors++;
      $error("FAIL %s out_valid observed=%b expected=%b", tag, out_valid, pend_v);
    end
    if (pend_v) begin
      hold_out = pend_out;
      hold_ovf = pend_ovf;
    end
    checks++;
    assert (OUT === hold_out) else begin
      errors++;
      $error("FAIL %s OUT observed=%h expected=%h", tag, OUT, hold_out);
    end
    checks++;
    assert (ovf === hold_ovf) else begin
      errors++;
      $error("FAIL %s ovf observed=%b expected=%b", tag, ovf, hold_ovf);
    end
  endtask

  // One clock step: present inputs, take the edge, check the output of the
  // previous step's operation, then queue this step's expectation.
  task automatic step(input string tag, input logic iv,
                      input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] eo, input logic ef);
    in_valid = iv;
    A        = a;
    B        = b;
    @(posedge clock);
    #1;
    check_out(tag);
    pend_v   = iv;
    pend_out = eo;
    pend_ovf = ef;
  endtask

  logic [15:0] da [9] = '{16'h00AA, 16'h0001, 16'hFFFD, 16'h80A8, 16'hF0FF,
                          16'hF050, 16'h8000, 16'h8000, 16'h00AA};
  logic [15:0] db [9] = '{16'h0092, 16'h0011, 16'h00A0, 16'h0024, 16'hF0FF,
                          16'hF034, 16'h7FFF, 16'h8000, 16'h0092};
  logic [15:0] dout [9] = '{16'h00C1, 16'h0000, 16'hFFFC, 16'hDC2F, 16'h7FFF,
                            16'h7FFF, 16'h8000, 16'h7FFF, 16'h00C1};
  logic        dovf [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    logic [15:0] ra, rb, ro;
    logic        rf, riv;

    pend_v   = 1'b0;
    pend_out = '0;
    pend_ovf = 1'b0;
    hold_out = '0;
    hold_ovf = 1'b0;
    in_valid = 1'b0;
    A        = '0;
    B        = '0;

    // Reset state before any clock edge.
    reset = 1'b1;
    #1;
    check_out("reset_async");
    @(posedge clock);
    @(posedge clock);
    #1;
    check_out("reset_held");
    reset = 1'b0;

    // Six directed vectors back to back, one bubble, three more.
    for (int i = 0; i < 6; i++)
      step($sformatf("dir%0d", i), 1'b1, da[i], db[i], dout[i], dovf[i]);
    step("bubble", 1'b0, 16'h1234, 16'h5678, 16'h0000, 1'b0);
    for (int i = 6; i < 9; i++)
      step($sformatf("dir%0d", i), 1'b1, da[i], db[i], dout[i], dovf[i]);
    step("drain0", 1'b0, '0, '0, '0, 1'b0);
    step("drain1", 1'b0, '0, '0, '0, 1'b0);

    // Reset with two operations in flight: outputs clear at once and the
    // discarded operations never emerge.
    step("pre_rst0", 1'b1, 16'h00AA, 16'h0092, 16'h00C1, 1'b0);
    step("pre_rst1", 1'b1, 16'hF0FF, 16'hF0FF, 16'h7FFF, 1'b1);
    in_valid = 1'b1;
    A        = 16'h0100;
    B        = 16'h0100;
    #2;
    reset    = 1'b1;
    #1;
    pend_v   = 1'b0;
    hold_out = '0;
    hold_ovf = 1'b0;
    check_out("rst_mid");
    @(posedge clock);
    #1;
    check_out("rst_edge");
    in_valid = 1'b0;
    reset    = 1'b0;
    for (int i = 0; i < 3; i++)
      step($sformatf("post_rst%0d", i), 1'b0, 16'hFFFF, 16'hFFFF, '0, 1'b0);
    step("post_rst_op", 1'b1, 16'hFFFD, 16'h00A0, 16'hFFFC, 1'b0);
    step("post_rst_out", 1'b0, '0, '0, '0, 1'b0);

    // Random operands with random valid, biased toward range extremes.
    for (int i = 0; i < 10000; i++) begin
      riv = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       ra = 16'h8000;
        1:       ra = 16'h7FFF;
        default: ra = 16'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       rb = 16'h8000;
        1:       rb = 16'hFFFF;
        default: rb = 16'($urandom);
      endcase
      ref_mult(ra, rb, ro, rf);
      step("rand", riv, ra, rb, ro, rf);
    end
    step("rand_drain", 1'b0, '0, '0, '0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
